// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the MIPS-lite pipeline (no-forwarding build).
// Performs word loads/stores against an internal data memory, owns the MEM/WB
// pipeline register and stalls upstream for MEM_LATENCY cycles per access.
//
// Build option: define MEM_ALIGN_CHECK_EN to suppress misaligned loads/stores
// and flag them on the sticky alignErr output. Without it, address bits [1:0]
// are ignored and alignErr is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting EX/MEM; non-memory ops complete at the next edge
// WAIT    | memory access in flight; counter counts remaining stall cycles
// HALTED  | HALT retired; stage frozen until reset

module mem_access_stage #(
    parameter int DATA          = 32,
    parameter int REGISTERWIDTH = 5,
    parameter int MEM_DEPTH     = 1024,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exValid,
    input  logic [DATA-1:0]          exAluResult,
    input  logic [DATA-1:0]          exStoreData,
    input  logic [REGISTERWIDTH-1:0] exRd,
    input  logic                     exMemRead,
    input  logic                     exMemWrite,
    input  logic                     exRegWrite,
    input  logic                     exWbMux,
    input  logic                     exHalt,
    output logic                     memStall,
    output logic                     wbValid,
    output logic [DATA-1:0]          writeBackData,
    output logic [DATA-1:0]          memDataOut,
    output logic [REGISTERWIDTH-1:0] memRd,
    output logic                     wbRegWrite,
    output logic                     wbMux,
    output logic                     haltSignal,
    output logic                     alignErr
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int LAT_M1 = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_M1);
    localparam bit HAS_LATENCY = (MEM_LATENCY != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [DATA-1:0]          wb_data_q, wb_data_d;
    logic [DATA-1:0]          mem_data_q, mem_data_d;
    logic [REGISTERWIDTH-1:0] rd_q, rd_d;
    logic                     wb_reg_write_q, wb_reg_write_d;
    logic                     wb_mux_q, wb_mux_d;
    logic                     halt_q, halt_d;

    logic [DATA-1:0]          mem_q [MEM_DEPTH];
    logic [IDX_W-1:0]         mem_idx;
    logic [DATA-1:0]          mem_rdata;
    logic                     mem_we;

    logic                     is_mem;
    logic                     is_store;
    logic                     is_load;
    logic                     misaligned;
    logic                     complete;
    logic                     stall;

    // Decode the EX/MEM bundle; both read and write set is treated as a store.
    always_comb begin
        is_mem    = exValid & (exMemRead | exMemWrite);
        is_store  = is_mem & exMemWrite;
        is_load   = is_mem & ~exMemWrite;
        mem_idx   = exAluResult[IDX_W+1:2];
        mem_rdata = mem_q[mem_idx];
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = is_mem & (exAluResult[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
    end

    // Stall and completion decision for the current cycle.
    always_comb begin
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem && HAS_LATENCY) begin
                    stall = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_HALTED: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    assign memStall = stall;

    // Next-state, latency counter and MEM/WB capture; non-completing edges load a bubble.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        halt_d         = halt_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = '0;
        mem_data_d     = '0;
        rd_d           = '0;
        wb_reg_write_d = 1'b0;
        wb_mux_d       = 1'b0;
        mem_we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stall) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        if (complete) begin
            wb_valid_d     = exValid;
            wb_data_d      = exAluResult;
            rd_d           = exRd;
            wb_mux_d       = exWbMux;
            wb_reg_write_d = exRegWrite & exValid & ~is_store & ~misaligned;
            mem_data_d     = (is_load & ~misaligned) ? mem_rdata : '0;
            mem_we         = is_store & ~misaligned;
            // A halt riding on a load/store only takes effect here, after the access.
            if (exValid & exHalt) begin
                halt_d  = 1'b1;
                state_d = ST_HALTED;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Pipeline register, FSM state and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            mem_data_q     <= '0;
            rd_q           <= '0;
            wb_reg_write_q <= 1'b0;
            wb_mux_q       <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            mem_data_q     <= mem_data_d;
            rd_q           <= rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_mux_q       <= wb_mux_d;
            halt_q         <= halt_d;
        end
    end

    // Data memory; reset clears every word, so an aborted store leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= exStoreData;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    // Sticky misalignment flag, raised when the offending access completes.
    always_comb begin
        align_err_d = align_err_q | (complete & misaligned);
    end

    // Misalignment flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign alignErr = align_err_q;
`else
    assign alignErr = 1'b0;
`endif

    assign wbValid       = wb_valid_q;
    assign writeBackData = wb_data_q;
    assign memDataOut    = mem_data_q;
    assign memRd         = rd_q;
    assign wbRegWrite    = wb_reg_write_q;
    assign wbMux         = wb_mux_q;
    assign haltSignal    = halt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written reset/halt
// sequences, and random traffic checked against a word-array reference model.

module tb_mem_access_stage;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic [31:0] exAluResult;
    logic [31:0] exStoreData;
    logic [4:0]  exRd;
    logic        exMemRead, exMemWrite, exRegWrite, exWbMux, exHalt;
    logic        memStall, wbValid, wbRegWrite, wbMux, haltSignal, alignErr;
    logic [31:0] writeBackData, memDataOut;
    logic [4:0]  memRd;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA(32), .REGISTERWIDTH(5), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .exValid(exValid), .exAluResult(exAluResult), .exStoreData(exStoreData),
        .exRd(exRd), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exRegWrite(exRegWrite), .exWbMux(exWbMux), .exHalt(exHalt),
        .memStall(memStall), .wbValid(wbValid), .writeBackData(writeBackData),
        .memDataOut(memDataOut), .memRd(memRd), .wbRegWrite(wbRegWrite),
        .wbMux(wbMux), .haltSignal(haltSignal), .alignErr(alignErr)
    );

    typedef struct {
        bit          v;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        bit          r, w, rw, wbm, halt;
    } op_t;

    typedef struct {
        int          stalls;
        bit          valid;
        logic [31:0] wbd;
        logic [31:0] md;
        logic [4:0]  rd;
        bit          rwr, wbm, halt, aerr;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [DEPTH];
    bit          aerr_m;
    bit          halt_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic op_t mk_op(bit v, logic [31:0] a, logic [31:0] sd, logic [4:0] rd,
                                  bit r, bit w, bit rw, bit wbm, bit halt);
        op_t o;
        o.v = v; o.addr = a; o.sdata = sd; o.rd = rd;
        o.r = r; o.w = w; o.rw = rw; o.wbm = wbm; o.halt = halt;
        return o;
    endfunction

    function automatic res_t mk_res(int st, bit valid, logic [31:0] wbd, logic [31:0] md,
                                    logic [4:0] rd, bit rwr, bit wbm, bit aerr);
        res_t e;
        e.stalls = st; e.valid = valid; e.wbd = wbd; e.md = md; e.rd = rd;
        e.rwr = rwr; e.wbm = wbm; e.halt = 1'b0; e.aerr = aerr;
        return e;
    endfunction

    // Reference model: word-addressed array, addresses wrap modulo DEPTH words.
    task automatic model_op(input op_t o, output res_t e);
        bit is_mem, st, ld, mis;
        int idx;
        logic [1:0] lo;
        is_mem = o.v && (o.r || o.w);
        st     = is_mem && o.w;
        ld     = is_mem && !o.w;
        lo     = o.addr[1:0];
`ifdef MEM_ALIGN_CHECK_EN
        mis = is_mem && (lo != 2'b00);
`else
        mis = 1'b0;
        lo  = 2'b00;
`endif
        idx      = int'((o.addr / 4) % DEPTH);
        e.stalls = is_mem ? LAT : 0;
        e.valid  = o.v;
        e.wbd    = o.addr;
        e.rd     = o.rd;
        e.wbm    = o.wbm;
        e.rwr    = o.v && o.rw && !st && !mis;
        e.md     = (ld && !mis) ? mdl[idx] : 32'h0;
        if (st && !mis) mdl[idx] = o.sdata;
        if (mis) aerr_m = 1'b1;
        if (o.v && o.halt) halt_m = 1'b1;
        e.aerr = aerr_m;
        e.halt = halt_m;
    endtask

    task automatic drive(input op_t o);
        exValid = o.v; exAluResult = o.addr; exStoreData = o.sdata; exRd = o.rd;
        exMemRead = o.r; exMemWrite = o.w; exRegWrite = o.rw; exWbMux = o.wbm;
        exHalt = o.halt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        aerr_m = 1'b0;
        halt_m = 1'b0;
    endtask

    // Holds the op stable until it completes; checks bubbles while stalled.
    task automatic run_op(input op_t o, output res_t got);
        int n;
        bit tmo;
        n   = 0;
        tmo = 1'b0;
        drive(o);
        #1;
        while (memStall === 1'b1 && !tmo) begin
            @(posedge clk); #1;
            n++;
            chk("bubble_wbValid", {31'b0, wbValid}, 32'h0);
            chk("bubble_wbRegWrite", {31'b0, wbRegWrite}, 32'h0);
            if (n > 20) tmo = 1'b1;
        end
        chk("stall_timeout", {31'b0, tmo}, 32'h0);
        @(posedge clk); #1;
        got.stalls = n;
        got.valid = wbValid; got.wbd = writeBackData; got.md = memDataOut;
        got.rd = memRd; got.rwr = wbRegWrite; got.wbm = wbMux;
        got.halt = haltSignal; got.aerr = alignErr;
    endtask

    task automatic cmp(input string tag, input res_t g, input res_t e);
        chk({tag, ".stalls"},        g.stalls, e.stalls);
        chk({tag, ".wbValid"},       {31'b0, g.valid}, {31'b0, e.valid});
        chk({tag, ".writeBackData"}, g.wbd, e.wbd);
        chk({tag, ".memDataOut"},    g.md, e.md);
        chk({tag, ".memRd"},         {27'b0, g.rd}, {27'b0, e.rd});
        chk({tag, ".wbRegWrite"},    {31'b0, g.rwr}, {31'b0, e.rwr});
        chk({tag, ".wbMux"},         {31'b0, g.wbm}, {31'b0, e.wbm});
        chk({tag, ".haltSignal"},    {31'b0, g.halt}, {31'b0, e.halt});
        chk({tag, ".alignErr"},      {31'b0, g.aerr}, {31'b0, e.aerr});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".memStall"},      {31'b0, memStall}, 32'h0);
        chk({tag, ".wbValid"},       {31'b0, wbValid}, 32'h0);
        chk({tag, ".writeBackData"}, writeBackData, 32'h0);
        chk({tag, ".memDataOut"},    memDataOut, 32'h0);
        chk({tag, ".memRd"},         {27'b0, memRd}, 32'h0);
        chk({tag, ".wbRegWrite"},    {31'b0, wbRegWrite}, 32'h0);
        chk({tag, ".wbMux"},         {31'b0, wbMux}, 32'h0);
        chk({tag, ".haltSignal"},    {31'b0, haltSignal}, 32'h0);
        chk({tag, ".alignErr"},      {31'b0, alignErr}, 32'h0);
    endtask

    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t got, exp;
        op_t  o;

        tbl[0] = '{mk_op(1'b1, 32'h10, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0),
                   mk_res(LAT, 1'b1, 32'h10, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0)};
        tbl[1] = '{mk_op(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
                   mk_res(LAT, 1'b1, 32'h10, 32'hDEADBEEF, 5'd5, 1'b1, 1'b1, 1'b0)};
        tbl[2] = '{mk_op(1'b1, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                   mk_res(0, 1'b1, 32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0)};
        tbl[3] = '{mk_op(1'b1, 32'h1000, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
                   mk_res(LAT, 1'b1, 32'h1000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0)};
        tbl[4] = '{mk_op(1'b1, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
                   mk_res(LAT, 1'b1, 32'h0, 32'h55, 5'd9, 1'b1, 1'b1, 1'b0)};
        tbl[5] = '{mk_op(1'b0, 32'hABC, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
                   mk_res(0, 1'b0, 32'hABC, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0)};
        tbl[6] = '{mk_op(1'b1, 32'h10, 32'h0BADF00D, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0),
                   mk_res(LAT, 1'b1, 32'h10, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0)};
        tbl[7] = '{mk_op(1'b1, 32'h10, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
                   mk_res(LAT, 1'b1, 32'h10, 32'h0BADF00D, 5'd2, 1'b1, 1'b1, 1'b0)};
`ifdef MEM_ALIGN_CHECK_EN
        tbl[8] = '{mk_op(1'b1, 32'h13, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
                   mk_res(LAT, 1'b1, 32'h13, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1)};
`else
        tbl[8] = '{mk_op(1'b1, 32'h13, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0),
                   mk_res(LAT, 1'b1, 32'h13, 32'h0BADF00D, 5'd6, 1'b1, 1'b1, 1'b0)};
`endif

        // Reset state.
        @(posedge clk); #1;
        do_reset();
        chk_all_zero("reset");

        // Directed vector table.
        foreach (tbl[i]) begin
            run_op(tbl[i].op, got);
            cmp($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Reset during WAIT of a store aborts it and clears memory.
        do_reset();
        o = mk_op(1'b1, 32'h24, 32'h77, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_op(o, exp);
        run_op(o, got);
        cmp("st24", got, exp);
        drive(mk_op(1'b1, 32'h20, 32'h99, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        chk("rstwait.stall0", {31'b0, memStall}, 32'h1);
        @(posedge clk); #1;
        chk("rstwait.stall1", {31'b0, memStall}, 32'h1);
        rst = 1'b1;
        drive(mk_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("rstwait");
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        aerr_m = 1'b0;
        o = mk_op(1'b1, 32'h20, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        model_op(o, exp);
        run_op(o, got);
        cmp("ld20", got, exp);
        o = mk_op(1'b1, 32'h24, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        model_op(o, exp);
        run_op(o, got);
        cmp("ld24", got, exp);

        // Halt on an ALU op freezes the stage until reset.
        do_reset();
        o = mk_op(1'b1, 32'h40, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        model_op(o, exp);
        run_op(o, got);
        cmp("halt", got, exp);
        drive(mk_op(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("halted.stall", {31'b0, memStall}, 32'h1);
            chk("halted.wbValid", {31'b0, wbValid}, 32'h0);
            chk("halted.wbRegWrite", {31'b0, wbRegWrite}, 32'h0);
            chk("halted.haltSignal", {31'b0, haltSignal}, 32'h1);
        end
        drive(mk_op(1'b1, 32'h10, 32'h5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        chk("halted2.wbValid", {31'b0, wbValid}, 32'h0);
        chk("halted2.haltSignal", {31'b0, haltSignal}, 32'h1);
        do_reset();
        chk_all_zero("halt_rst");

        // Halt carried on a load takes effect after the load returns data.
        o = mk_op(1'b1, 32'h8, 32'hCAFE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_op(o, exp);
        run_op(o, got);
        cmp("st8", got, exp);
        o = mk_op(1'b1, 32'h8, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        model_op(o, exp);
        run_op(o, got);
        cmp("ld8halt", got, exp);
        drive(mk_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        chk("ld8halt.stall", {31'b0, memStall}, 32'h1);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            if (kind == 0 && $urandom_range(0, 1) == 1) a = $urandom;
            o = mk_op($urandom_range(0, 9) != 0, a, $urandom, 5'($urandom_range(0, 31)),
                      (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
            model_op(o, exp);
            run_op(o, got);
            cmp($sformatf("rnd%0d", n), got, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
